// File: rtl/keypad_scanner_4x4_if.sv
// keypad_scanner_4x4_if
// Bundles the keypad matrix lines and the key-code outputs of the scanner.
//   row_in      : keypad rows, active low, asynchronous to clk
//   col_out     : keypad column drive, exactly one bit low
//   clear_tries : synchronous clear of the press counter
//   onehot      : held key code, bit index = row*4 + col
//   key_valid   : one-cycle pulse per accepted press
//   tries       : saturating count of accepted presses
// master = scanner side, slave = keypad / downstream side.
interface keypad_scanner_4x4_if;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic        clear_tries;
   logic [15:0] onehot;
   logic        key_valid;
   logic [7:0]  tries;

   modport master (
      input  row_in,
      input  clear_tries,
      output col_out,
      output onehot,
      output key_valid,
      output tries
   );

   modport slave (
      output row_in,
      output clear_tries,
      input  col_out,
      input  onehot,
      input  key_valid,
      input  tries
   );
endinterface

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4
// Scans a 4x4 matrix keypad one column at a time, debounces press and
// release of a single key and reports it as a held one-hot code with a
// one-cycle valid pulse and a saturating press counter.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   bus   : keypad_scanner_4x4_if.master (row_in, col_out, clear_tries,
//           onehot, key_valid, tries)
//
// state    | meaning
// ---------+----------------------------------------------------------
// SCAN     | walk columns; on a tick with exactly one row low, latch it
// DEBOUNCE | column frozen; count stable ticks of the latched row
// HELD     | key accepted; count all-high ticks until release confirmed
module keypad_scanner_4x4 #(
   parameter int SCAN_DIV     = 50000,
   parameter int DEBOUNCE_CNT = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   keypad_scanner_4x4_if.master    bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   // one bit low at position idx; used both for column drive and for the
   // expected row pattern of the latched key
   function automatic logic [3:0] one_cold(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

   logic [3:0]       row_s1, row_s2;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   state_t           state;
   logic [1:0]       col_idx;
   logic [1:0]       row_idx;
   logic [CNT_W-1:0] deb_cnt;
   logic [3:0]       col_out_q;
   logic [15:0]      onehot_q;
   logic             key_valid_q;
   logic [7:0]       tries_q;

   logic             one_low;
   logic [1:0]       low_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1  <= 4'hF;
         row_s2  <= 4'hF;
         div_cnt <= '0;
      end else begin
         row_s1  <= bus.row_in;
         row_s2  <= row_s1;
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   // two or more rows low means ghosting or a multi-key press: not a key
   always_comb begin
      one_low = 1'b0;
      low_idx = 2'd0;
      case (row_s2)
         4'b1110: begin one_low = 1'b1; low_idx = 2'd0; end
         4'b1101: begin one_low = 1'b1; low_idx = 2'd1; end
         4'b1011: begin one_low = 1'b1; low_idx = 2'd2; end
         4'b0111: begin one_low = 1'b1; low_idx = 2'd3; end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         row_idx     <= 2'd0;
         deb_cnt     <= '0;
         col_out_q   <= 4'b1110;
         onehot_q    <= 16'h0000;
         key_valid_q <= 1'b0;
         tries_q     <= 8'd0;
      end else begin
         key_valid_q <= 1'b0;
         // an accepted press below overrides this with the post-clear count
         if (bus.clear_tries)
            tries_q <= 8'd0;

         if (tick) begin
            case (state)
               SCAN: begin
                  if (one_low) begin
                     row_idx <= low_idx;
                     deb_cnt <= '0;
                     state   <= DEBOUNCE;
                  end else begin
                     col_idx   <= col_idx + 2'd1;
                     col_out_q <= one_cold(col_idx + 2'd1);
                  end
               end
               DEBOUNCE: begin
                  if (row_s2 == one_cold(row_idx)) begin
                     if (deb_cnt == CNT_LAST) begin
                        onehot_q    <= 16'h0001 << {row_idx, col_idx};
                        key_valid_q <= 1'b1;
                        if (bus.clear_tries)
                           tries_q <= 8'd1;
                        else if (tries_q != 8'hFF)
                           tries_q <= tries_q + 8'd1;
                        deb_cnt <= '0;
                        state   <= HELD;
                     end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                     end
                  end else begin
                     deb_cnt   <= '0;
                     col_idx   <= col_idx + 2'd1;
                     col_out_q <= one_cold(col_idx + 2'd1);
                     state     <= SCAN;
                  end
               end
               HELD: begin
                  if (row_s2 == 4'hF) begin
                     if (deb_cnt == CNT_LAST) begin
                        deb_cnt   <= '0;
                        col_idx   <= col_idx + 2'd1;
                        col_out_q <= one_cold(col_idx + 2'd1);
                        state     <= SCAN;
                     end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                     end
                  end else begin
                     deb_cnt <= '0;
                  end
               end
               default: begin
                  deb_cnt <= '0;
                  state   <= SCAN;
               end
            endcase
         end
      end
   end

   assign bus.col_out   = col_out_q;
   assign bus.onehot    = onehot_q;
   assign bus.key_valid = key_valid_q;
   assign bus.tries     = tries_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
module tb_keypad_scanner_4x4;

   logic        clk;
   logic        rst_n;
   logic [15:0] pressed;
   logic [3:0]  row_v;
   int          n_cmp;
   int          n_err;

   keypad_scanner_4x4_if kp_if ();

   keypad_scanner_4x4 #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kp_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // physical keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_v = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !kp_if.col_out[c])
               row_v[r] = 1'b0;
   end
   assign kp_if.row_in = row_v;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // waits (at negedges) until col_out leaves target and then returns to it
   task automatic wait_col(input logic [3:0] target, output bit ok);
      int n;
      n = 0;
      while (kp_if.col_out == target && n < 100) begin @(negedge clk); n++; end
      while (kp_if.col_out != target && n < 100) begin @(negedge clk); n++; end
      ok = (kp_if.col_out == target);
   endtask

   task automatic wait_change(output bit ok);
      logic [3:0] c0;
      int n;
      c0 = kp_if.col_out;
      n  = 0;
      while (kp_if.col_out == c0 && n < 100) begin @(negedge clk); n++; end
      ok = (kp_if.col_out != c0);
   endtask

   task automatic wait_valid(input int budget, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         ok = kp_if.key_valid;
      end
   endtask

   task automatic chk_ok(input string name, input bit ok);
      n_cmp++;
      if (ok !== 1'b1) begin
         n_err++;
         $display("FAIL %s: got timeout expected event", name);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      int pulses;
      rst_n = 1'b0;
      pressed = '0;
      kp_if.clear_tries = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (kp_if.col_out !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b expected 1110", kp_if.col_out); end
      n_cmp++; if (kp_if.onehot !== 16'h0000) begin n_err++; $display("FAIL reset_onehot: got %h expected 0000", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd0) begin n_err++; $display("FAIL reset_tries: got %0d expected 0", kp_if.tries); end
      n_cmp++; if (kp_if.key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", kp_if.key_valid); end
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         exp = ~(4'b0001 << ((i / 4) % 4));
         if (kp_if.key_valid) pulses++;
         n_cmp++;
         if (kp_if.col_out !== exp) begin
            n_err++;
            $display("FAIL scan_seq[%0d]: got %b expected %b", i, kp_if.col_out, exp);
         end
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
      n_cmp++; if (kp_if.onehot !== 16'h0000) begin n_err++; $display("FAIL idle_onehot: got %h expected 0000", kp_if.onehot); end
   endtask

   task automatic test_clean_press();
      bit ok;
      int n, pulses, moved;
      wait_col(4'b1110, ok); chk_ok("clean_sync_col0", ok);
      pressed[6] = 1'b1;
      wait_col(4'b1011, ok); chk_ok("clean_reach_col2", ok);
      wait_valid(40, n, ok); chk_ok("clean_valid", ok);
      n_cmp++; if (n !== 16) begin n_err++; $display("FAIL clean_latency: got %0d expected 16", n); end
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL clean_onehot: got %h expected 0040", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd1) begin n_err++; $display("FAIL clean_tries: got %0d expected 1", kp_if.tries); end
      @(negedge clk);
      n_cmp++; if (kp_if.key_valid !== 1'b0) begin n_err++; $display("FAIL clean_pulse_width: got %b expected 0", kp_if.key_valid); end
      pulses = 0; moved = 0;
      repeat (80) begin
         @(negedge clk);
         if (kp_if.key_valid) pulses++;
         if (kp_if.col_out != 4'b1011) moved++;
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL held_repeat: got %0d expected 0", pulses); end
      n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL held_col_frozen: got %0d expected 0", moved); end
      pressed = '0;
      wait_change(ok); chk_ok("release_scan", ok);
      n_cmp++; if (kp_if.col_out !== 4'b0111) begin n_err++; $display("FAIL release_next_col: got %b expected 0111", kp_if.col_out); end
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL release_onehot_hold: got %h expected 0040", kp_if.onehot); end
   endtask

   task automatic test_bounce();
      bit ok;
      int pulses;
      wait_col(4'b1110, ok); chk_ok("bounce_sync", ok);
      pressed[0] = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (kp_if.col_out !== 4'b1110) begin n_err++; $display("FAIL bounce_col_hold: got %b expected 1110", kp_if.col_out); end
      pressed = '0;
      pulses = 0;
      repeat (4) begin @(negedge clk); if (kp_if.key_valid) pulses++; end
      n_cmp++; if (kp_if.col_out !== 4'b1101) begin n_err++; $display("FAIL bounce_resume: got %b expected 1101", kp_if.col_out); end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL bounce_pulse: got %0d expected 0", pulses); end
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL bounce_onehot: got %h expected 0040", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd1) begin n_err++; $display("FAIL bounce_tries: got %0d expected 1", kp_if.tries); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int n;
      pressed[15] = 1'b1;
      wait_valid(100, n, ok); chk_ok("key15_valid", ok);
      n_cmp++; if (kp_if.onehot !== 16'h8000) begin n_err++; $display("FAIL key15_onehot: got %h expected 8000", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd2) begin n_err++; $display("FAIL key15_tries: got %0d expected 2", kp_if.tries); end
      pressed = '0;
      wait_col(4'b1110, ok); chk_ok("key15_release", ok);
      pressed[12] = 1'b1;
      wait_valid(100, n, ok); chk_ok("key12_valid", ok);
      n_cmp++; if (kp_if.onehot !== 16'h1000) begin n_err++; $display("FAIL key12_onehot: got %h expected 1000", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd3) begin n_err++; $display("FAIL key12_tries: got %0d expected 3", kp_if.tries); end
      pressed = '0;
      wait_col(4'b1101, ok); chk_ok("key12_release", ok);
   endtask

   task automatic test_ghost();
      bit ok;
      int pulses;
      wait_col(4'b1101, ok); chk_ok("ghost_sync", ok);
      pressed[1] = 1'b1;
      pressed[9] = 1'b1;
      pulses = 0;
      repeat (4) begin @(negedge clk); if (kp_if.key_valid) pulses++; end
      n_cmp++; if (kp_if.col_out !== 4'b1011) begin n_err++; $display("FAIL ghost_advance: got %b expected 1011", kp_if.col_out); end
      pressed = '0;
      repeat (4) begin @(negedge clk); if (kp_if.key_valid) pulses++; end
      n_cmp++; if (kp_if.col_out !== 4'b0111) begin n_err++; $display("FAIL ghost_scan: got %b expected 0111", kp_if.col_out); end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL ghost_pulse: got %0d expected 0", pulses); end
      n_cmp++; if (kp_if.onehot !== 16'h1000) begin n_err++; $display("FAIL ghost_onehot: got %h expected 1000", kp_if.onehot); end
   endtask

   task automatic test_saturate();
      bit ok, all_ok;
      int n;
      all_ok = 1'b1;
      for (int i = 0; i < 252; i++) begin
         pressed[5] = 1'b1;
         wait_valid(100, n, ok);
         if (!ok) all_ok = 1'b0;
         pressed = '0;
         wait_change(ok);
         if (!ok) all_ok = 1'b0;
      end
      chk_ok("preload_presses", all_ok);
      n_cmp++; if (kp_if.tries !== 8'd255) begin n_err++; $display("FAIL preload_tries: got %0d expected 255", kp_if.tries); end
      pressed[5] = 1'b1;
      wait_valid(100, n, ok); chk_ok("sat_valid", ok);
      n_cmp++; if (kp_if.tries !== 8'd255) begin n_err++; $display("FAIL sat_tries: got %0d expected 255", kp_if.tries); end
      n_cmp++; if (kp_if.onehot !== 16'h0020) begin n_err++; $display("FAIL sat_onehot: got %h expected 0020", kp_if.onehot); end
      pressed = '0;
      wait_change(ok); chk_ok("sat_release", ok);
   endtask

   task automatic test_clear_coincident();
      bit ok;
      wait_col(4'b1110, ok); chk_ok("clr_sync", ok);
      pressed[6] = 1'b1;
      wait_col(4'b1011, ok); chk_ok("clr_reach_col2", ok);
      repeat (15) @(negedge clk);
      kp_if.clear_tries = 1'b1;
      @(negedge clk);
      kp_if.clear_tries = 1'b0;
      n_cmp++; if (kp_if.key_valid !== 1'b1) begin n_err++; $display("FAIL clr_press_valid: got %b expected 1", kp_if.key_valid); end
      n_cmp++; if (kp_if.tries !== 8'd1) begin n_err++; $display("FAIL clr_press_tries: got %0d expected 1", kp_if.tries); end
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL clr_press_onehot: got %h expected 0040", kp_if.onehot); end
      pressed = '0;
      wait_change(ok); chk_ok("clr_release", ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      wait_col(4'b1110, ok); chk_ok("rstmid_sync", ok);
      pressed[6] = 1'b1;
      wait_col(4'b1011, ok); chk_ok("rstmid_reach_col2", ok);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (kp_if.col_out !== 4'b1110) begin n_err++; $display("FAIL rstmid_col: got %b expected 1110", kp_if.col_out); end
      n_cmp++; if (kp_if.onehot !== 16'h0000) begin n_err++; $display("FAIL rstmid_onehot: got %h expected 0000", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd0) begin n_err++; $display("FAIL rstmid_tries: got %0d expected 0", kp_if.tries); end
      n_cmp++; if (kp_if.key_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", kp_if.key_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid(100, n, ok); chk_ok("rstmid_redetect", ok);
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL rstmid_re_onehot: got %h expected 0040", kp_if.onehot); end
      n_cmp++; if (kp_if.tries !== 8'd1) begin n_err++; $display("FAIL rstmid_re_tries: got %0d expected 1", kp_if.tries); end
      pressed = '0;
      wait_change(ok); chk_ok("rstmid_release", ok);
   endtask

   task automatic test_clear_idle();
      kp_if.clear_tries = 1'b1;
      @(negedge clk);
      kp_if.clear_tries = 1'b0;
      n_cmp++; if (kp_if.tries !== 8'd0) begin n_err++; $display("FAIL clear_idle: got %0d expected 0", kp_if.tries); end
      n_cmp++; if (kp_if.onehot !== 16'h0040) begin n_err++; $display("FAIL clear_keeps_onehot: got %h expected 0040", kp_if.onehot); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      pressed = '0;
      kp_if.clear_tries = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_back_to_back();
      test_ghost();
      test_saturate();
      test_clear_coincident();
      test_reset_mid();
      test_clear_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
